// File: rtl/sram_resp_pkg.sv
// sram_resp_pkg: FSM state encoding and LFSR constants for the sram_resp memory responder
package sram_resp_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded on reset, advancing every cycle
module lfsr8
    import sram_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] out
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out <= LFSR_SEED;
        else     out <= {out[6:0], ^(out & LFSR_TAPS)};
    end
endmodule

// File: rtl/sram_resp.sv
// sram_resp: byte-masked SRAM responder with valid/ready channels; SRAM_RESP_RANDOM_DELAY_EN adds 0..3 random delay
module sram_resp
    import sram_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    state_t state, state_n;
    logic [4:0] cnt, cnt_n, load;
    logic wen;
    logic [31:0] addr, wdata, off;
    logic [3:0] wmask;
    logic [31:0] mem [DEPTH_WORDS];
    logic in_range, accept, fire, done;
    logic [AW-1:0] idx;
`ifdef SRAM_RESP_RANDOM_DELAY_EN
    logic [7:0] lfsr;
    lfsr8 u_lfsr (.clk(clk), .rst(rst), .out(lfsr));
    assign load = 5'(LATENCY) + 5'(lfsr & 8'h03);
`else
    assign load = 5'(LATENCY);
`endif
    // Below BASE_ADDR the subtraction wraps, so the lower-bound test is separate.
    assign off = addr - BASE_ADDR;
    assign in_range = addr >= BASE_ADDR && (off >> 2) < 32'(DEPTH_WORDS);
    assign idx = AW'(off >> 2);
    assign req_ready = state == IDLE;
    assign accept = req_valid && req_ready;
    assign fire = state == WAIT && cnt == 5'd1;
    assign done = state == RESP && rsp_ready;
    always_comb begin
        state_n = accept ? WAIT : fire ? RESP : done ? IDLE : state;
        cnt_n = accept ? load : state == WAIT ? cnt - 5'd1 : cnt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (fire) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= (!wen && in_range) ? mem[idx] : '0;
                rsp_err   <= !in_range;
            end else if (done) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            wen   <= req_wen;
            addr  <= req_addr;
            wdata <= req_wdata;
            wmask <= req_wmask;
        end
    end
    always_ff @(posedge clk) begin
        if (fire && wen && in_range)
            for (int b = 0; b < 4; b++)
                if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_sram_resp.sv
// tb_sram_resp: table vectors, corner-case sequences and random traffic against a reference memory model
module tb_sram_resp;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_wen = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0] req_wmask = '0;
    logic req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    int checks = 0, errors = 0;
    logic [31:0] ref_mem [longint];

    sram_resp #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

`ifdef SRAM_RESP_RANDOM_DELAY_EN
    logic [7:0] m;
    always @(posedge clk or posedge rst)
        if (rst) m <= 8'hA5;
        else     m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    function automatic int exp_lat();
        return LAT + int'(m[1:0]);
    endfunction
`else
    function automatic int exp_lat();
        return LAT;
    endfunction
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed window [BASE, BASE+4*DEPTH), one word per 4 bytes.
    task automatic ref_access(input bit wen, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] wm, output logic [31:0] er, output logic ee);
        longint ai = longint'(a);
        longint i = (ai - longint'(BASE)) / 4;
        logic [31:0] w;
        er = '0;
        ee = !(ai >= longint'(BASE) && ai < longint'(BASE) + 4 * DEPTH);
        if (!ee) begin
            w = ref_mem.exists(i) ? ref_mem[i] : '0;
            if (wen) begin
                for (int b = 0; b < 4; b++) if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
                ref_mem[i] = w;
            end else er = w;
        end
    endtask

    task automatic run(input string name, input bit wen, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] wm, input logic [31:0] exp_rd, input logic exp_err);
        int n = 0, lat = 0, elat;
        req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd; req_wmask = wm;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        elat = exp_lat();
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = ~wen; req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom);
        while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk({name, "_lat"}, 32'(lat), 32'(elat));
        chk({name, "_rdata"}, rsp_rdata, exp_rd);
        chk({name, "_err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({name, "_after_vld_err_rdy"}, {29'b0, rsp_valid, rsp_err, req_ready}, 32'd1);
        chk({name, "_after_rdata"}, rsp_rdata, 32'd0);
    endtask

    typedef struct {
        bit wen; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wmask;
        logic [31:0] rdata; logic err;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tv[$];
        logic [31:0] er, rd;
        logic ee;
        int lat;
        tv.push_back('{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0});
        tv.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0});
        tv.push_back('{1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0010, 32'h0, 1'b0});
        tv.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_33EF, 1'b0});
        tv.push_back('{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0});
        tv.push_back('{1'b0, 32'h7FFF_FFFC, 32'h0,         4'hF, 32'h0, 1'b1});
        tv.push_back('{1'b0, 32'h8000_1000, 32'h0,         4'hF, 32'h0, 1'b1});
        tv.push_back('{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0, 1'b1});
        tv.push_back('{1'b0, 32'h8000_0000, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0});
        tv.push_back('{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0});
        tv.push_back('{1'b0, 32'h8000_0013, 32'h0,         4'hF, 32'hDEAD_33EF, 1'b0});
        tv.push_back('{1'b1, 32'h8000_0FFC, 32'h0BAD_CAFE, 4'hF, 32'h0, 1'b0});
        tv.push_back('{1'b0, 32'h8000_0FFC, 32'h0,         4'hF, 32'h0BAD_CAFE, 1'b0});
        tv.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0, 1'b1});

        #2;
        chk("reset_rdy_vld_err", {29'b0, req_ready, rsp_valid, rsp_err}, 32'd4);
        chk("reset_rdata", rsp_rdata, 32'd0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tv[k]) begin
            ref_access(tv[k].wen, tv[k].addr, tv[k].wdata, tv[k].wmask, er, ee);
            run($sformatf("tv%0d", k), tv[k].wen, tv[k].addr, tv[k].wdata, tv[k].wmask, tv[k].rdata, tv[k].err);
        end

        // Response held under backpressure while a second request waits.
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_wmask = 4'hF;
        @(posedge clk); #1;
        req_wen = 1'b1; req_addr = 32'h8000_0030; req_wdata = 32'h0BAD_F00D; req_wmask = 4'hF;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            chk("bp_wait_rdy", 32'(req_ready), 32'd0);
            @(posedge clk); #1; lat++;
        end
        chk("bp_first_rdata", rsp_rdata, 32'hDEAD_33EF);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_vld_rdy", c), {30'b0, rsp_valid, req_ready}, 32'd2);
            chk($sformatf("bp_hold%0d_rdata", c), rsp_rdata, 32'hDEAD_33EF);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_handshake_vld_rdy", {30'b0, rsp_valid, req_ready}, 32'd1);
        lat = exp_lat();
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_second_accepted", 32'(req_ready), 32'd0);
        ref_access(1'b1, 32'h8000_0030, 32'h0BAD_F00D, 4'hF, er, ee);
        begin
            int n = 0;
            while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
            chk("bp_second_lat", 32'(n), 32'(lat));
        end
        chk("bp_second_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        run("bp_readback", 1'b0, 32'h8000_0030, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0);

        // Reset in the middle of WAIT drops a pending write.
        ref_access(1'b1, 32'h8000_0020, 32'h5A5A_5A5A, 4'hF, er, ee);
        run("rst_prewrite", 1'b1, 32'h8000_0020, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'hFFFF_FFFF; req_wmask = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_in_wait_rdy", 32'(req_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_vld_rdy", {30'b0, rsp_valid, req_ready}, 32'd1);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_rdy", 32'(req_ready), 32'd1);
        run("rst_readback", 1'b0, 32'h8000_0020, 32'h0, 4'hF, 32'h5A5A_5A5A, 1'b0);

        // Back-to-back reads: latency follows the delay model every time.
        for (int k = 0; k < 20; k++)
            run($sformatf("b2b%0d", k), 1'b0, 32'h8000_0010, 32'h0, 4'hF, 32'hDEAD_33EF, 1'b0);

        // Random traffic over a small word pool plus out-of-range addresses.
        for (int k = 0; k < 17; k++) begin
            logic [31:0] a = k < 16 ? BASE + 32'h200 + 32'(4 * k) : BASE + 32'(4 * (DEPTH - 1));
            logic [31:0] d = $urandom;
            ref_access(1'b1, a, d, 4'hF, er, ee);
            run($sformatf("init%0d", k), 1'b1, a, d, 4'hF, er, ee);
        end
        for (int k = 0; k < 60; k++) begin
            int r = $urandom_range(0, 20);
            bit w = 1'($urandom);
            logic [31:0] d = $urandom;
            logic [3:0] wm = 4'($urandom);
            logic [31:0] a;
            if (r < 16)       a = BASE + 32'h200 + 32'(4 * r) + 32'($urandom_range(0, 3));
            else if (r == 16) a = BASE - 32'(4 * $urandom_range(1, 4));
            else if (r == 17) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            else if (r == 18) a = 32'h0;
            else              a = BASE + 32'(4 * (DEPTH - 1));
            ref_access(w, a, d, wm, er, ee);
            run($sformatf("rnd%0d", k), w, a, d, wm, er, ee);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
